fetch_unit: RTL and testbench

Instruction fetch stage that drives the instruction memory and feeds the IF/ID pipeline register. It holds the architectural fetch PC and issues in-order requests over a grant/one-cycle-response memory port. Returned words are buffered with their PCs in a small prefetch FIFO, and the FIFO head is presented to decode under the pipeline's advance signal. A redirect from the branch path flushes all buffered and in-flight work and restarts fetch at the target.

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//
// Holds the architectural fetch PC and issues in-order word fetches over a
// request/grant port whose response arrives exactly one cycle after the grant.
// Returned words are queued with their PCs in a small prefetch FIFO. The FIFO
// head is presented to decode and is consumed under the pipeline advance
// signal. A redirect flushes everything buffered and in flight and restarts
// fetch at the (word-aligned) target.
//
// Parameters
//   WIDTH     address / instruction width
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous reset, active low
//   imem_req        fetch request valid
//   imem_addr       fetch address (word aligned)
//   imem_gnt        memory accepts the request this cycle
//   imem_rvalid     response valid, one cycle after a grant
//   imem_rdata      instruction word returned with imem_rvalid
//   redirect_valid  taken branch / jump, restart fetch
//   redirect_pc     restart target, low two bits ignored
//   instr_valid     FIFO head holds an instruction
//   instr           FIFO head instruction, NOP when not valid
//   instr_pc        FIFO head PC, zero when not valid
//   instr_ready     decode consumes the head this cycle
module fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
);

  localparam int unsigned      PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CntW     = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] Nop      = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] PcStep   = WIDTH'(4);
  localparam logic [CntW:0]    DepthOcc = (CntW + 1)'(DEPTH);

  // Control state
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             pending_q, pending_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;

  // FIFO storage; contents are only observable while count_q is non-zero,
  // so it carries no reset.
  logic [WIDTH-1:0] fifo_instr_q [DEPTH];
  logic [WIDTH-1:0] fifo_pc_q    [DEPTH];

  logic [CntW:0] occupancy;
  logic          grant;
  logic          push;
  logic          pop;
  logic          head_valid;

  // Target alignment drops the two low bits of the redirect address.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Request / handshake decode. A granted request reserves a FIFO slot while
  // its response is in flight, so buffered plus pending can never exceed DEPTH.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, pending_q};
    imem_req   = rst & ~redirect_valid & (occupancy < DepthOcc);
    imem_addr  = rst ? fetch_pc_q : RESET_PC;
    grant      = imem_req & imem_gnt;
    head_valid = rst & (count_q != '0);
    // Only a response to a request granted last cycle is accepted; this also
    // drops strays in the first cycle after reset release.
    push       = rst & pending_q & imem_rvalid & ~redirect_valid;
    pop        = head_valid & instr_ready & ~redirect_valid;
  end

  // Next-state logic
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pending_d  = grant;
    count_d    = count_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
      pending_d  = 1'b0;
      count_d    = '0;
      rptr_d     = '0;
      wptr_d     = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + PcStep;
        pend_pc_d  = fetch_pc_q;
      end
      if (push) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pending_q  <= 1'b0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wptr_q] <= imem_rdata;
      fifo_pc_q[wptr_q]    <= pend_pc_q;
    end
  end

  // Decode-facing outputs come from registered FIFO state only.
  always_comb begin
    instr_valid = head_valid;
    instr       = head_valid ? fifo_instr_q[rptr_q] : Nop;
    instr_pc    = head_valid ? fifo_pc_q[rptr_q] : '0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios, a queue-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_fetch_unit;

  localparam int unsigned Width   = 32;
  localparam int unsigned Depth   = 4;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(
    .WIDTH   (Width),
    .DEPTH   (Depth),
    .RESET_PC(ResetPc)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: fetch PC, one in-flight slot, FIFO as a queue.
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic        m_pend = 1'b0;
  logic [31:0] m_pc   = ResetPc;
  logic [31:0] m_ppc  = 32'h0;

  always @(posedge clk) begin
    bit m_req;
    bit m_pop;
    bit m_push;
    if (!rst) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc   = ResetPc;
    end else if (redirect_valid) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc   = {redirect_pc[31:2], 2'b00};
    end else begin
      m_req  = (mq.size() + int'(m_pend)) < Depth;
      m_pop  = (mq.size() > 0) && instr_ready;
      m_push = m_pend && imem_rvalid;
      if (m_push) begin
        checks++;
        if (mq.size() >= Depth && !m_pop) begin
          failures++;
          $display("FAIL fifo_overflow: actual=push_when_full required=no_push");
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{word: imem_rdata, pc: m_ppc});
      if (m_req && imem_gnt) begin
        m_ppc  = m_pc;
        m_pc   = m_pc + 32'd4;
        m_pend = 1'b1;
      end else begin
        m_pend = 1'b0;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  logic [31:0] pop_log[$];

  always @(negedge clk) begin
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    e_req   = rst && !redirect_valid && ((mq.size() + int'(m_pend)) < Depth);
    e_addr  = rst ? m_pc : ResetPc;
    e_valid = rst && (mq.size() > 0);
    e_instr = e_valid ? mq[0].word : 32'h0000_0013;
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    check("cyc_imem_req", imem_req, e_req);
    check("cyc_imem_addr", imem_addr, e_addr);
    check("cyc_instr_valid", instr_valid, e_valid);
    check("cyc_instr", instr, e_instr);
    check("cyc_instr_pc", instr_pc, e_pc);
    if (rst && !redirect_valid && instr_valid && instr_ready) pop_log.push_back(instr_pc);
  end

  // Memory responder: answers each grant one cycle later.
  logic        mem_take;
  logic [31:0] mem_addr;
  int          grants = 0;

  task automatic tick();
    @(negedge clk);
    mem_take = imem_req & imem_gnt;
    mem_addr = imem_addr;
    if (mem_take) grants++;
    @(posedge clk);
    #1;
    imem_rvalid = mem_take;
    imem_rdata  = mem_take ? mem_word(mem_addr) : 32'h0;
  endtask

  initial begin
    rst            = 1'b0;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;

    // Reset values
    tick();
    tick();
    #1;
    check("rst_req", imem_req, 32'd0);
    check("rst_addr", imem_addr, ResetPc);
    check("rst_valid", instr_valid, 32'd0);
    check("rst_instr", instr, 32'h13);
    check("rst_pc", instr_pc, 32'd0);

    // Streaming after release
    rst = 1'b1;
    #1;
    check("t1_c0_req", imem_req, 32'd1);
    check("t1_c0_addr", imem_addr, 32'h0);
    check("t1_c0_valid", instr_valid, 32'd0);
    tick(); #1;
    check("t1_c1_addr", imem_addr, 32'h4);
    check("t1_c1_valid", instr_valid, 32'd0);
    tick(); #1;
    check("t1_c2_valid", instr_valid, 32'd1);
    check("t1_c2_instr", instr, 32'h1000);
    check("t1_c2_pc", instr_pc, 32'h0);
    tick(); #1;
    check("t1_c3_instr", instr, 32'h1001);
    check("t1_c3_pc", instr_pc, 32'h4);
    check("t1_c3_addr", imem_addr, 32'hc);
    repeat (4) tick();

    // Decode stall from empty: FIFO fills with exactly DEPTH grants
    rst = 1'b0;
    tick();
    rst         = 1'b1;
    instr_ready = 1'b0;
    grants      = 0;
    repeat (10) tick();
    #1;
    check("t2_grants", grants, 32'd4);
    check("t2_req_off", imem_req, 32'd0);
    check("t2_head_pc", instr_pc, 32'h0);
    pop_log.delete();
    instr_ready = 1'b1;
    tick(); #1;
    check("t2_resume_req", imem_req, 32'd1);
    check("t2_resume_addr", imem_addr, 32'h10);
    repeat (6) tick();
    check("t2_log_len", 32'(pop_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < pop_log.size()) check("t2_pop_pc", pop_log[i], 32'(4 * i));
    end

    // Grant withheld for three cycles
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    pop_log.delete();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_addr_hold", imem_addr, 32'h200);
      check("t3_req_hold", imem_req, 32'd1);
      tick();
    end
    imem_gnt = 1'b1;
    repeat (8) tick();
    check("t3_log_len", 32'(pop_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_log.size()) check("t3_pop_pc", pop_log[i], 32'h200 + 32'(4 * i));
    end

    // Redirect with 3 buffered, a response and a pop in the same cycle
    instr_ready = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    instr_ready    = 1'b1;
    #1;
    check("t4_r_valid", instr_valid, 32'd1);
    check("t4_r_req", imem_req, 32'd0);
    tick();
    redirect_valid = 1'b0;
    pop_log.delete();
    #1;
    check("t4_r1_valid", instr_valid, 32'd0);
    check("t4_r1_req", imem_req, 32'd1);
    check("t4_r1_addr", imem_addr, 32'h100);
    tick(); #1;
    check("t4_r2_valid", instr_valid, 32'd0);
    tick(); #1;
    check("t4_r3_valid", instr_valid, 32'd1);
    check("t4_r3_pc", instr_pc, 32'h100);
    check("t4_r3_instr", instr, 32'h1040);
    repeat (3) tick();
    check("t4_log_len", 32'(pop_log.size() >= 1), 32'd1);
    if (pop_log.size() >= 1) check("t4_first_pop", pop_log[0], 32'h100);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    check("t5_addr_wrap", imem_addr, 32'h0);
    tick(); #1;
    check("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
    check("t5_instr_top", instr, 32'h4000_0FFF);
    tick(); #1;
    check("t5_pc_wrap", instr_pc, 32'h0);
    check("t5_instr_wrap", instr, 32'h1000);

    // Reset pulse mid-stream with a response in flight
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("t6_rst_req", imem_req, 32'd0);
    check("t6_rst_valid", instr_valid, 32'd0);
    check("t6_rst_instr", instr, 32'h13);
    check("t6_rst_pc", instr_pc, 32'h0);
    check("t6_rst_addr", imem_addr, ResetPc);
    tick();
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("t6_c0_valid", instr_valid, 32'd0);
    check("t6_c0_req", imem_req, 32'd1);
    check("t6_c0_addr", imem_addr, ResetPc);
    tick(); #1;
    check("t6_c1_valid", instr_valid, 32'd0);
    tick(); #1;
    check("t6_c2_valid", instr_valid, 32'd1);
    check("t6_c2_instr", instr, 32'h1000);
    check("t6_c2_pc", instr_pc, 32'h0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
